centroid_divider: RTL

Downstream stage of the tracking FSM: when a frame completes, it takes the accumulated x/y coordinate sums and the found-pixel count and computes the target centroid (x_pos, y_pos) with a shared-control, bit-serial restoring divider. The result feeds the drag-and-stamp cursor logic. An empty frame (count = 0) is flagged and does not update the position.

---
 rtl/tracking_pkg.sv | 18 +
 rtl/restoring_div_step.sv | 48 ++++
 rtl/centroid_divider.sv | 116 +++++++++++
 3 files changed

// File: rtl/tracking_pkg.sv
// Shared tracking-pipeline constants and types.
// Holds frame geometry, centroid widths and the divider state enum.
package tracking_pkg;

  localparam int SUM_W   = 28;
  localparam int CNT_W   = 19;
  localparam int POS_W   = 10;
  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DIVIDE,
    FINISH
  } cd_state_e;

endpackage

// File: rtl/restoring_div_step.sv
// One bit-serial restoring divider lane (dividend, remainder, quotient).
// Ports: clk, reset, load, step, dividend, divisor -> q_next (post-step quotient).
module restoring_div_step
  import tracking_pkg::*;
#(
  parameter int SW = SUM_W,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [SW-1:0] dividend,
  input  logic [CW-1:0] divisor,
  output logic [SW-1:0] q_next
);

  logic [SW-1:0] d_r;
  logic [CW:0]   rem_r;
  logic [SW-2:0] q_r;
  logic [CW+1:0] rem_sh;
  logic [CW+1:0] div_x;
  logic          qb;

  always_comb begin
    rem_sh = {rem_r, d_r[SW-1]};
    div_x  = {2'b00, divisor};
    qb     = (rem_sh >= div_x);
    q_next = {q_r, qb};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_r   <= '0;
      rem_r <= '0;
      q_r   <= '0;
    end else if (load) begin
      d_r   <= dividend;
      rem_r <= '0;
      q_r   <= '0;
    end else if (step) begin
      d_r   <= {d_r[SW-2:0], 1'b0};
      rem_r <= (CW+1)'(qb ? rem_sh - div_x : rem_sh);
      q_r   <= q_next[SW-2:0];
    end
  end

endmodule

// File: rtl/centroid_divider.sv
// Frame centroid: floor(x_sum/count), floor(y_sum/count), saturated to POS_W.
// Ports: start/x_sum/y_sum/count in; busy, done, x_pos, y_pos, no_target out.
module centroid_divider
  import tracking_pkg::*;
#(
  parameter int SUM_W = tracking_pkg::SUM_W,
  parameter int CNT_W = tracking_pkg::CNT_W,
  parameter int POS_W = tracking_pkg::POS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] x_sum,
  input  logic [SUM_W-1:0] y_sum,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             no_target
);

  localparam int IW = $clog2(SUM_W);

  cd_state_e state, state_nx;

  logic [SUM_W-1:0] xs_r;
  logic [SUM_W-1:0] ys_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IW-1:0]    iter;
  logic [SUM_W-1:0] xq;
  logic [SUM_W-1:0] yq;
  logic             empty;
  logic             load;
  logic             step;
  logic             last;

  function automatic logic [POS_W-1:0] sat(
    input logic [SUM_W-1:0] q
  );
    return (|q[SUM_W-1:POS_W]) ? '1 : q[POS_W-1:0];
  endfunction

  assign empty = (cnt_r == '0);
  assign load  = (state == CHECK) && !empty;
  assign step  = (state == DIVIDE);
  assign last  = step && (iter == '0);
  assign busy  = (state != IDLE);
  assign done  = (state == FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CHECK;
      CHECK:   state_nx = empty ? FINISH : DIVIDE;
      DIVIDE:  if (iter == '0) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xs_r      <= '0;
      ys_r      <= '0;
      cnt_r     <= '0;
      iter      <= '0;
      x_pos     <= '0;
      y_pos     <= '0;
      no_target <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        xs_r  <= x_sum;
        ys_r  <= y_sum;
        cnt_r <= count;
      end
      if (state == CHECK) begin
        iter <= IW'(SUM_W - 1);
        if (empty) no_target <= 1'b1;
      end
      if (step) iter <= iter - 1'b1;
      // q_next already holds the final bit on the last step edge
      if (last) begin
        x_pos     <= sat(xq);
        y_pos     <= sat(yq);
        no_target <= 1'b0;
      end
    end
  end

  restoring_div_step #(.SW(SUM_W), .CW(CNT_W)) u_x (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .dividend (xs_r),
    .divisor  (cnt_r),
    .q_next   (xq)
  );

  restoring_div_step #(.SW(SUM_W), .CW(CNT_W)) u_y (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .dividend (ys_r),
    .divisor  (cnt_r),
    .q_next   (yq)
  );

endmodule
